// File: rtl/state_control.sv
// Top-level sequencing FSM: IDLE -> INIT -> RUN -> DONE, handshaking on a level start
// request and a datapath finish indication; the state code is exported for enable decode.
`timescale 1ns/1ps
module state_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       finish,
  output logic       done,
  output logic [2:0] state
);

  localparam int unsigned StateW = 3;

  typedef enum logic [StateW-1:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    RUN  = 3'd2,
    DONE = 3'd3
  } state_e;

  // Raw code register so that illegal encodings remain representable and recoverable.
  logic [StateW-1:0] state_q, state_d;
  logic              done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StateW'(IDLE);
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      StateW'(IDLE): if (start)  state_d = StateW'(INIT);
      StateW'(INIT):             state_d = StateW'(RUN);
      StateW'(RUN):  if (finish) state_d = StateW'(DONE);
      StateW'(DONE): if (!start) state_d = StateW'(IDLE);
      default:                   state_d = StateW'(IDLE);
    endcase
    // done tracks the next state so it flips on the same edge as the state code.
    done_d = (state_d == StateW'(DONE));
  end

  assign state = state_q;
  assign done  = done_q;

endmodule

// File: tb/tb_state_control.sv
// Directed, time-scripted bench for state_control with hand-computed expected codes.
`timescale 1ns/1ps
module tb_state_control;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       finish;
  logic       done;
  logic [2:0] state;

  int checks;
  int errors;

  state_control dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .finish (finish),
    .done   (done),
    .state  (state)
  );

  // 6 ns clock, rising edges at 3 + 6k ns.
  initial clk = 1'b0;
  always #3 clk = ~clk;

  task automatic go(input int t);
    if (int'($time) < t) #(t - int'($time));
  endtask

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_sd(input string tag, input logic [2:0] exp_state, input logic exp_done);
    chk({tag, "_state"}, state, exp_state);
    chk({tag, "_done"}, {2'b00, done}, {2'b00, exp_done});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    finish = 1'b0;

    go(10);  chk_sd("reset_hold", 3'd0, 1'b0);
    go(20);  rst_n = 1'b1;

    // finish while idle must not move the FSM
    go(40);  finish = 1'b1;
    go(58);  chk_sd("finish_in_idle", 3'd0, 1'b0);
    go(60);  finish = 1'b0;

    // nominal job
    go(120); start = 1'b1;
    go(122); chk_sd("pre_start_edge", 3'd0, 1'b0);
    go(124); chk_sd("init_after_start", 3'd1, 1'b0);
    go(130); chk_sd("run_after_init", 3'd2, 1'b0);
    go(200); start = 1'b0;
    go(212); start = 1'b1;
    go(220); chk_sd("start_toggle_in_run", 3'd2, 1'b0);
    go(318); chk_sd("run_hold", 3'd2, 1'b0);
    go(320); finish = 1'b1;
    go(322); chk_sd("done_first_finish_edge", 3'd3, 1'b1);
    go(340); finish = 1'b0;
    go(346); chk_sd("done_while_start_high", 3'd3, 1'b1);
    go(398); chk_sd("done_hold", 3'd3, 1'b1);

    // release, then finish high only across the INIT->RUN edge
    go(400); start = 1'b0;
    go(406); chk_sd("release_to_idle", 3'd0, 1'b0);
    go(410); start = 1'b1;
    go(412); chk_sd("restart_init", 3'd1, 1'b0);
    go(413); finish = 1'b1;
    go(418); chk_sd("finish_on_init_edge", 3'd2, 1'b0);
    go(419); finish = 1'b0;
    go(424); chk_sd("finish_not_remembered", 3'd2, 1'b0);

    // single-cycle finish, then a stray finish pulse in DONE
    go(430); finish = 1'b1;
    go(436); chk_sd("single_cycle_finish", 3'd3, 1'b1);
    go(437); finish = 1'b0;
    go(450); finish = 1'b1;
    go(456); finish = 1'b0;
    go(458); chk_sd("finish_in_done", 3'd3, 1'b1);

    // start falls and finish rises on the same RUN edge
    go(470); start = 1'b0;
    go(472); chk_sd("idle_again", 3'd0, 1'b0);
    go(480); start = 1'b1;
    go(490); chk_sd("run_job3", 3'd2, 1'b0);
    go(492); start = 1'b0; finish = 1'b1;
    go(496); chk_sd("same_edge_done", 3'd3, 1'b1);
    go(497); finish = 1'b0;
    go(502); chk_sd("same_edge_then_idle", 3'd0, 1'b0);

    // asynchronous reset mid-RUN
    go(510); start = 1'b1;
    go(520); chk_sd("run_before_reset", 3'd2, 1'b0);
    go(522); rst_n = 1'b0; start = 1'b0;
    go(523); chk_sd("async_reset_mid_run", 3'd0, 1'b0);
    go(530); rst_n = 1'b1;
    go(534); chk_sd("after_reset_release", 3'd0, 1'b0);

    // illegal code recovery from DONE
    go(540); start = 1'b1;
    go(550); finish = 1'b1;
    go(556); chk_sd("done_before_illegal", 3'd3, 1'b1);
    go(557); finish = 1'b0;
    go(558); force dut.state_q = 3'd6;
    go(560); release dut.state_q;
    go(562); chk_sd("illegal_to_idle", 3'd0, 1'b0);
    go(568); chk_sd("restart_after_illegal", 3'd1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
